// File: rtl/cpu_mem_responder.sv
// Unified instruction/data memory responder for the pipelined MIPS core.
// Latency: 1 cycle registered read on both ports; counter and error flags at the MMIO/data port.
// Backpressure: none; accepts a new access every cycle on each port, zero wait states.
module cpu_mem_responder #(
  parameter int          ADDR_WIDTH    = 10,
  parameter logic [31:0] MMIO_CNT_ADDR = 32'hFFFF_FFF0
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        inst_ena,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  input  logic        data_ena,
  input  logic        data_wea,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        err_oob,
  output logic        err_misalign
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           cycle_cnt;

  logic [ADDR_WIDTH-1:0] inst_idx;
  logic [ADDR_WIDTH-1:0] data_idx;
  logic                  inst_in_range;
  logic                  data_in_range;
  logic                  inst_misal;
  logic                  data_misal;
  logic                  data_mmio;
  logic                  mem_we;
  logic                  mmio_we;
  logic                  collide;
  logic                  inst_oob;
  logic                  data_oob;

  // Address decode shared by the array, counter and error logic.
  always_comb begin
    inst_idx      = inst_addr[ADDR_WIDTH+1:2];
    data_idx      = data_addr[ADDR_WIDTH+1:2];
    inst_in_range = (inst_addr[31:ADDR_WIDTH+2] == '0);
    data_in_range = (data_addr[31:ADDR_WIDTH+2] == '0);
    inst_misal    = (inst_addr[1:0] != 2'b00);
    data_misal    = (data_addr[1:0] != 2'b00);
    // The counter address is only visible on the data port; on the
    // instruction port it is simply out of range.
    data_mmio     = (data_addr == MMIO_CNT_ADDR);
    // Misaligned and out-of-range writes never touch the array.
    mem_we        = !rst && data_ena && data_wea && data_in_range && !data_misal && !data_mmio;
    mmio_we       = data_ena && data_wea && data_mmio;
    // Same-word write and fetch in one cycle: the fetch sees the new data.
    collide       = inst_ena && mem_we && inst_in_range && (inst_idx == data_idx);
    inst_oob      = inst_ena && !inst_in_range;
    data_oob      = data_ena && !data_in_range && !data_mmio;
  end

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clka) begin
    if (mem_we) begin
      mem[data_idx] <= data_wdata;
    end
  end

  // Instruction read port with write bypass on collision; holds when idle.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      inst_rdata <= '0;
    end else if (inst_ena) begin
      if (!inst_in_range) begin
        inst_rdata <= '0;
      end else if (collide) begin
        inst_rdata <= data_wdata;
      end else begin
        inst_rdata <= mem[inst_idx];
      end
    end
  end

  // Data read port: counter, out-of-range zero, write-first, or array word.
  // A dropped misaligned write returns the aligned word like a read would.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      data_rdata <= '0;
    end else if (data_ena) begin
      if (data_mmio) begin
        data_rdata <= data_wea ? data_wdata : cycle_cnt;
      end else if (!data_in_range) begin
        data_rdata <= '0;
      end else if (mem_we) begin
        data_rdata <= data_wdata;
      end else begin
        data_rdata <= mem[data_idx];
      end
    end
  end

  // Free-running cycle counter; a software write wins over the increment.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (mmio_we) begin
      cycle_cnt <= data_wdata;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      err_oob      <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      if (inst_oob || data_oob) begin
        err_oob <= 1'b1;
      end
      if ((inst_ena && inst_misal) || (data_ena && data_misal)) begin
        err_misalign <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed scenarios plus randomized traffic,
// checked every cycle against a word-array reference model.
module tb_cpu_mem_responder;

  localparam int          AW   = 10;
  localparam int          WRDS = 1 << AW;
  localparam logic [31:0] MMIO = 32'hFFFF_FFF0;

  logic        clka = 1'b0;
  logic        rst;
  logic        inst_ena;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        data_ena;
  logic        data_wea;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        err_oob;
  logic        err_misalign;

  cpu_mem_responder #(.ADDR_WIDTH(AW), .MMIO_CNT_ADDR(MMIO)) dut (
    .clka(clka), .rst(rst),
    .inst_ena(inst_ena), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .data_ena(data_ena), .data_wea(data_wea), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .err_oob(err_oob), .err_misalign(err_misalign)
  );

  always #5 clka = ~clka;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] m_mem [WRDS];
  bit          m_known [WRDS];
  logic [31:0] m_cnt;
  logic [31:0] e_inst, e_data;
  bit          e_inst_k, e_data_k;
  bit          e_oob, e_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; e_inst = 0; e_data = 0; e_inst_k = 1; e_data_k = 1; e_oob = 0; e_mis = 0;
  endtask

  // What one clock edge must do, from the inputs presented before it.
  task automatic model_edge();
    logic [31:0] next_cnt;
    bit d_in, d_mmio, i_in;
    int di, ii;
    d_in   = (data_addr >> (AW + 2)) == 0;
    d_mmio = (data_addr == MMIO);
    di     = int'((data_addr >> 2) % WRDS);
    i_in   = (inst_addr >> (AW + 2)) == 0;
    ii     = int'((inst_addr >> 2) % WRDS);
    next_cnt = m_cnt + 1;
    if (data_ena) begin
      if (data_addr % 4 != 0) e_mis = 1;
      if (!d_in && !d_mmio) e_oob = 1;
      e_data_k = 1;
      if (d_mmio) begin
        e_data = data_wea ? data_wdata : m_cnt;
        if (data_wea) next_cnt = data_wdata;
      end else if (!d_in) begin
        e_data = 0;
      end else if (data_wea && data_addr % 4 == 0) begin
        m_mem[di] = data_wdata; m_known[di] = 1; e_data = data_wdata;
      end else begin
        e_data = m_mem[di]; e_data_k = m_known[di];
      end
    end
    // Fetch observes a same-edge write (bypass), so it reads the updated array.
    if (inst_ena) begin
      if (inst_addr % 4 != 0) e_mis = 1;
      if (!i_in) begin
        e_oob = 1; e_inst = 0; e_inst_k = 1;
      end else begin
        e_inst = m_mem[ii]; e_inst_k = m_known[ii];
      end
    end
    m_cnt = next_cnt;
  endtask

  task automatic compare();
    if (e_inst_k) chk("inst_rdata", inst_rdata, e_inst);
    if (e_data_k) chk("data_rdata", data_rdata, e_data);
    chk("err_oob", {31'd0, err_oob}, {31'd0, e_oob});
    chk("err_misalign", {31'd0, err_misalign}, {31'd0, e_mis});
  endtask

  task automatic cyc();
    @(posedge clka);
    if (!rst) model_edge();
    #1;
    compare();
  endtask

  task automatic set_d(input logic ena, input logic wea, input logic [31:0] a, input logic [31:0] wd);
    data_ena = ena; data_wea = wea; data_addr = a; data_wdata = wd;
  endtask

  task automatic set_i(input logic ena, input logic [31:0] a);
    inst_ena = ena; inst_addr = a;
  endtask

  // Mid-cycle reset: outputs must clear without waiting for an edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare();
    chk("rst_inst_zero", inst_rdata, 32'd0);
    chk("rst_data_zero", data_rdata, 32'd0);
    @(posedge clka);
    #1 compare();
    #2 rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input bit allow_mmio);
    int r;
    r = $urandom_range(0, 99);
    if (r < 2) return {$urandom_range(0, 15), 2'b00} | 32'($urandom_range(1, 3));
    if (r < 4) return $urandom | 32'h0001_0000;
    if (r < 8 && allow_mmio) return MMIO;
    if (r < 80) return 32'($urandom_range(0, 15)) << 2;
    return 32'($urandom_range(0, WRDS - 1)) << 2;
  endfunction

  initial begin
    for (int i = 0; i < WRDS; i++) begin
      m_known[i] = 0;
      m_mem[i]   = 0;
    end
    model_reset();
    set_d(0, 0, 0, 0);
    set_i(0, 0);
    rst = 1'b1;
    #2;
    chk("reset_inst", inst_rdata, 32'd0);
    chk("reset_data", data_rdata, 32'd0);
    chk("reset_oob", {31'd0, err_oob}, 32'd0);
    chk("reset_mis", {31'd0, err_misalign}, 32'd0);
    #1 rst = 1'b0;

    // Write-first then read back.
    set_d(1, 1, 32'h10, 32'hDEADBEEF); cyc();
    chk("write_first", data_rdata, 32'hDEADBEEF);
    set_d(1, 0, 32'h10, 0); cyc();
    chk("read_10", data_rdata, 32'hDEADBEEF);

    // Same-cycle write and fetch of one word.
    set_d(1, 1, 32'h20, 32'h1234_5678); set_i(1, 32'h20); cyc();
    chk("bypass", inst_rdata, 32'h1234_5678);
    set_d(0, 0, 0, 0); cyc();
    chk("fetch_20", inst_rdata, 32'h1234_5678);
    set_i(0, 0); cyc();
    chk("inst_hold", inst_rdata, 32'h1234_5678);

    // Out-of-range read and a write that must be dropped (aliases word 0).
    set_d(1, 1, 32'h0, 32'hA5A5_A5A5); cyc();
    set_d(1, 0, 32'h0001_0000, 0); cyc();
    chk("oob_rdata", data_rdata, 32'd0);
    chk("oob_flag", {31'd0, err_oob}, 32'd1);
    set_d(1, 1, 32'h0001_0000, 32'h1111_1111); cyc();
    chk("oob_wr_rdata", data_rdata, 32'd0);
    set_d(1, 0, 32'h0, 0); cyc();
    chk("oob_no_alias", data_rdata, 32'hA5A5_A5A5);
    chk("oob_sticky", {31'd0, err_oob}, 32'd1);

    // Misaligned write dropped, misaligned read returns the aligned word.
    set_d(1, 1, 32'h13, 32'hCAFE_F00D); cyc();
    chk("mis_flag", {31'd0, err_misalign}, 32'd1);
    set_d(1, 0, 32'h10, 0); cyc();
    chk("mis_dropped", data_rdata, 32'hDEADBEEF);
    set_d(1, 0, 32'h12, 0); cyc();
    chk("mis_read", data_rdata, 32'hDEADBEEF);

    // Counter load and wrap; the counter address is out of range for fetch.
    set_d(1, 1, MMIO, 32'hFFFF_FFFE); set_i(1, 32'h10); cyc();
    chk("mmio_wr_echo", data_rdata, 32'hFFFF_FFFE);
    chk("fetch_10", inst_rdata, 32'hDEADBEEF);
    set_d(0, 0, 0, 0); set_i(1, MMIO); cyc();
    chk("fetch_mmio_zero", inst_rdata, 32'd0);
    set_d(1, 0, MMIO, 0); set_i(0, 0); cyc();
    chk("cnt_ffffffff", data_rdata, 32'hFFFF_FFFF);
    cyc();
    chk("cnt_wrap", data_rdata, 32'd0);

    // Reset keeps the array but clears everything else.
    set_d(0, 0, 0, 0);
    do_reset();
    chk("rst_oob_clr", {31'd0, err_oob}, 32'd0);
    chk("rst_mis_clr", {31'd0, err_misalign}, 32'd0);
    set_d(1, 0, MMIO, 0); set_i(1, 32'h10); cyc();
    chk("cnt_after_rst", data_rdata, 32'd0);
    chk("mem_retained", inst_rdata, 32'hDEADBEEF);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      set_d($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rand_addr(1), $urandom);
      set_i($urandom_range(0, 3) != 0, rand_addr(0));
      if (data_addr == MMIO && data_wea && $urandom_range(0, 1) == 0) data_wdata = 32'hFFFF_FFFD;
      if ($urandom_range(0, 399) == 0) do_reset();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the pipelined MIPS core's two memory interfaces: one instruction-fetch port (read-only) and one data port (read/write).
- Backed by a single unified word array, with one-cycle registered read latency, BRAM-style.
- Adds a memory-mapped free-running cycle counter and sticky error flags for out-of-range and misaligned accesses.
- Sits at SoC top level, directly opposite the core's pc/instr and alu_result/mem_wdata/mem_rdata signals.

Parameters:
- ADDR_WIDTH, 10: word-address bits. Array depth is 2^ADDR_WIDTH words; valid byte range is 0 .. 4*2^ADDR_WIDTH-1.
- MMIO_CNT_ADDR, 32'hFFFF_FFF0: byte address of the cycle-counter register on the data port.

Ports:
- clka  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- inst_ena  in  1  instruction-port read enable.
- inst_addr  in  32  instruction byte address (core pc).
- inst_rdata  out  32  fetched instruction; valid the cycle after inst_ena.
- data_ena  in  1  data-port enable.
- data_wea  in  1  data write enable; qualified by data_ena.
- data_addr  in  32  data byte address (core alu_result).
- data_wdata  in  32  write data.
- data_rdata  out  32  read data; valid the cycle after data_ena.
- err_oob  out  1  sticky: any enabled access was out of range.
- err_misalign  out  1  sticky: any enabled access had addr[1:0] != 0.

Behaviour:
- Reset (async, immediate):
  - inst_rdata = 0, data_rdata = 0, err_oob = 0, err_misalign = 0, cycle counter = 0.
  - Array contents are not reset and are retained across a mid-run reset.
- Word index = addr[ADDR_WIDTH+1:2].
- In range: addr[31:ADDR_WIDTH+2] == 0.
- MMIO hit: data_addr == MMIO_CNT_ADDR. This applies to the data port only; on the instruction port that address is out of range.
- Instruction read (inst_ena=1, edge):
  - In range: inst_rdata <= array[index].
  - Out of range: inst_rdata <= 0.
  - inst_ena=0: inst_rdata holds its previous value.
- Data read (data_ena=1, data_wea=0, edge):
  - In range: data_rdata <= array[index].
  - MMIO hit: data_rdata <= counter value before this edge's update.
  - Otherwise: data_rdata <= 0.
  - data_ena=0: data_rdata holds.
- Data write (data_ena=1, data_wea=1, aligned, edge):
  - In range: array[index] <= data_wdata, and data_rdata <= data_wdata (write-first).
  - MMIO hit: counter <= data_wdata, and data_rdata <= data_wdata.
  - Out of range: write dropped, data_rdata <= 0.
- Misaligned access:
  - Writes are dropped.
  - Reads return the aligned word (low two bits ignored).
  - err_misalign <= 1 at that edge.
- Out-of-range access on either port: err_oob <= 1 at that edge. Both flags stay set until rst.
- Port collision (same cycle, in-range data write and instruction read of the same word): inst_rdata <= data_wdata, i.e. new data is bypassed.
- Simultaneous data and instruction reads of the same word are both served the same value; no arbitration and no stall.
- Cycle counter:
  - Increments by 1 every clock; wraps 32'hFFFF_FFFF -> 0.
  - An MMIO write takes priority over the increment on that edge; the increment resumes from the written value next cycle.
- Latency: exactly 1 cycle on both ports, zero wait states, full throughput (a new access every cycle on each port).

Test Plan:
- Write 32'hDEADBEEF to 0x10, then read 0x10 on the data port -> data_rdata = DEADBEEF one cycle after the read; data_rdata = DEADBEEF during the write cycle's response (write-first).
- Same cycle: data write 32'h1234_5678 to 0x20 and inst read of 0x20 -> inst_rdata = 12345678 next cycle; a later inst read of 0x20 also returns 12345678.
- Data read at 0x0001_0000 (ADDR_WIDTH=10) -> data_rdata = 0, err_oob = 1, persisting until rst. A subsequent write to the same address leaves the array unchanged.
- Write to 0x13 -> write dropped (read of 0x10 unchanged), err_misalign = 1. Read of 0x12 returns the word at 0x10.
- Write 32'hFFFF_FFFE to MMIO_CNT_ADDR, then read it 1 cycle later -> data_rdata = FFFFFFFF. A read 2 cycles after the write -> data_rdata = 0 (wrap).
- Assert rst mid-stream after several writes -> all outputs 0 immediately, flags cleared, counter 0. A post-reset read of 0x10 returns the pre-reset DEADBEEF.
